// File: rtl/eth_tx_framer_if.sv
// Byte-stream handshake between the TX frame buffer readout (master) and
// eth_tx_framer (slave). A byte moves when s_valid_i & s_ready_o.
interface eth_tx_framer_if;
  logic [7:0] s_data_i;
  logic       s_valid_i;
  logic       s_last_i;
  logic       s_ready_o;

  modport master (output s_data_i, s_valid_i, s_last_i, input  s_ready_o);
  modport slave  (input  s_data_i, s_valid_i, s_last_i, output s_ready_o);
endinterface

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, CRC-32 FCS, inter-frame gap, underrun abort.
// Define ETH_TX_PAD_EN to zero-pad short frames to MIN_FRAME payload bytes (pad is CRC-covered).
module eth_tx_framer #(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  eth_tx_framer_if.slave s,
  output logic [7:0]     gmii_txd_o,
  output logic           gmii_tx_en_o,
  output logic           gmii_tx_er_o,
  output logic           busy_o,
  output logic           underrun_o,
  output logic [15:0]    frame_cnt_o
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
`ifdef ETH_TX_PAD_EN
  localparam logic [2:0] S_PAD  = 3'd4;
`endif
  localparam logic [2:0] S_FCS  = 3'd5;
  localparam logic [2:0] S_IFG  = 3'd6;

  localparam int          CMAX = (IFG_BYTES > 7) ? IFG_BYTES : 7;
  localparam int          CW   = $clog2(CMAX + 1);
  localparam logic [31:0] POLY = 32'hEDB88320;

  if (IFG_BYTES < 1 || MIN_FRAME < 1 || MIN_FRAME > 2047) begin : g_bad_cfg
    $error("eth_tx_framer: IFG_BYTES must be >= 1 and MIN_FRAME in 1..2047");
  end

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0]   bcnt_q, bcnt_d, bcnt_sat;
  logic [31:0]   crc_q, crc_d, fcs;
  logic [15:0]   frame_cnt_q, fc_d;
  logic [7:0]    txd_d;
  logic          en_d, er_d, ur_d;

  assign bcnt_sat = (bcnt_q == 11'h7FF) ? bcnt_q : bcnt_q + 11'd1;
  assign fcs      = ~crc_q;

`ifdef ETH_TX_PAD_EN
  // True while the byte being emitted now still leaves the frame short.
  logic short_frm;
  assign short_frm = ({1'b0, bcnt_q} + 12'd1) < 12'(MIN_FRAME);
`endif

  assign s.s_ready_o  = (state_q == S_DATA);
  assign busy_o       = (state_q != S_IDLE);
  assign frame_cnt_o  = frame_cnt_q;

  // Outputs are computed for the byte that goes on the wire next cycle,
  // so each state emits one byte ahead of where its name suggests.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    crc_d   = crc_q;
    fc_d    = frame_cnt_q;
    txd_d   = 8'h00;
    en_d    = 1'b0;
    er_d    = 1'b0;
    ur_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (s.s_valid_i) begin
          state_d = S_PRE;
          cnt_d   = '0;
          bcnt_d  = '0;
          crc_d   = '1;
          txd_d   = 8'h55;
          en_d    = 1'b1;
        end
      end
      S_PRE: begin
        txd_d = 8'h55;
        en_d  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(5)) state_d = S_SFD;
      end
      S_SFD: begin
        txd_d   = 8'hD5;
        en_d    = 1'b1;
        state_d = S_DATA;
      end
      S_DATA: begin
        en_d = 1'b1;
        if (s.s_valid_i) begin
          txd_d  = s.s_data_i;
          crc_d  = crc_byte(crc_q, s.s_data_i);
          bcnt_d = bcnt_sat;
          if (s.s_last_i) begin
            cnt_d   = '0;
            state_d = S_FCS;
`ifdef ETH_TX_PAD_EN
            if (short_frm) state_d = S_PAD;
`endif
          end
        end else begin
          // Upstream ran dry mid-frame: poison it on the wire and abandon.
          er_d    = 1'b1;
          ur_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_IFG;
        end
      end
`ifdef ETH_TX_PAD_EN
      S_PAD: begin
        en_d   = 1'b1;
        crc_d  = crc_byte(crc_q, 8'h00);
        bcnt_d = bcnt_sat;
        if (!short_frm) begin
          cnt_d   = '0;
          state_d = S_FCS;
        end
      end
`endif
      S_FCS: begin
        en_d  = 1'b1;
        txd_d = 8'(fcs >> {cnt_q[1:0], 3'b000});
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(3)) begin
          fc_d    = frame_cnt_q + 16'd1;
          cnt_d   = '0;
          state_d = S_IFG;
        end
      end
      S_IFG: begin
        // IFG_BYTES+1 cycles here: the first still shows the final FCS/abort byte.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(IFG_BYTES)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bcnt_q       <= '0;
      crc_q        <= '1;
      frame_cnt_q  <= '0;
      gmii_txd_o   <= 8'h00;
      gmii_tx_en_o <= 1'b0;
      gmii_tx_er_o <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bcnt_q       <= bcnt_d;
      crc_q        <= crc_d;
      frame_cnt_q  <= fc_d;
      gmii_txd_o   <= txd_d;
      gmii_tx_en_o <= en_d;
      gmii_tx_er_o <= er_d;
      underrun_o   <= ur_d;
    end
  end
endmodule
